// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer: multi-cycle decode/settle/capture controller for the ALU
// datapath. Optional perf counters enabled by `define ALU_SEQ_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  dp_rs_number,
  output logic [4:0]  dp_rt_number,
  output logic [15:0] dp_imm_16,
  output logic        dp_alusrc,
  output logic [3:0]  dp_alucontrol,
  input  logic [31:0] dp_alu_result,
  input  logic        dp_zero,
  input  logic        dp_ovfl,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_zero,
  output logic        res_ovfl,
  output logic        res_illegal
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0] perf_instr_cnt,
  output logic [15:0] perf_ovfl_cnt,
  output logic [15:0] perf_illegal_cnt
`endif
);

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_NOR  = 4'b1100;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [15:0] imm_q, imm_d;
  logic        alusrc_q, alusrc_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_zero_q, res_zero_d;
  logic        res_ovfl_q, res_ovfl_d;
  logic        res_illegal_q, res_illegal_d;

  logic        dec_legal;
  logic        dec_alusrc;
  logic [3:0]  dec_ctl;

  always_comb begin
    dec_legal  = 1'b1;
    dec_alusrc = 1'b1;
    dec_ctl    = CTL_AND;
    case (instr[31:26])
      6'h00: begin
        dec_alusrc = 1'b0;
        case (instr[5:0])
          6'h20:   dec_ctl = CTL_ADD;
          6'h22:   dec_ctl = CTL_SUB;
          6'h24:   dec_ctl = CTL_AND;
          6'h25:   dec_ctl = CTL_OR;
          6'h27:   dec_ctl = CTL_NOR;
          6'h2A:   dec_ctl = CTL_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h23, 6'h2B: dec_ctl = CTL_ADD;
      6'h0A:               dec_ctl = CTL_SLT;
      default:             dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    imm_d         = imm_q;
    alusrc_d      = alusrc_q;
    ctl_d         = ctl_q;
    res_data_d    = res_data_q;
    res_zero_d    = res_zero_q;
    res_ovfl_d    = res_ovfl_q;
    res_illegal_d = res_illegal_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (dec_legal) begin
            rs_d     = instr[25:21];
            rt_d     = instr[20:16];
            imm_d    = instr[15:0];
            alusrc_d = dec_alusrc;
            ctl_d    = dec_ctl;
            cnt_d    = CNT_INIT;
            state_d  = EXEC;
          end else begin
            // Illegal words skip the datapath, leaving dp_* at the last legal decode.
            res_data_d    = 32'd0;
            res_zero_d    = 1'b0;
            res_ovfl_d    = 1'b0;
            res_illegal_d = 1'b1;
            state_d       = DONE;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          res_data_d    = dp_alu_result;
          res_zero_d    = dp_zero;
          res_ovfl_d    = dp_ovfl;
          res_illegal_d = 1'b0;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      rs_q          <= 5'd0;
      rt_q          <= 5'd0;
      imm_q         <= 16'd0;
      alusrc_q      <= 1'b0;
      ctl_q         <= 4'd0;
      res_data_q    <= 32'd0;
      res_zero_q    <= 1'b0;
      res_ovfl_q    <= 1'b0;
      res_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      imm_q         <= imm_d;
      alusrc_q      <= alusrc_d;
      ctl_q         <= ctl_d;
      res_data_q    <= res_data_d;
      res_zero_q    <= res_zero_d;
      res_ovfl_q    <= res_ovfl_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  assign instr_ready   = (state_q == IDLE);
  assign res_valid     = (state_q == DONE);
  assign dp_rs_number  = rs_q;
  assign dp_rt_number  = rt_q;
  assign dp_imm_16     = imm_q;
  assign dp_alusrc     = alusrc_q;
  assign dp_alucontrol = ctl_q;
  assign res_data      = res_data_q;
  assign res_zero      = res_zero_q;
  assign res_ovfl      = res_ovfl_q;
  assign res_illegal   = res_illegal_q;

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_instr_q, perf_instr_d;
  logic [15:0] perf_ovfl_q, perf_ovfl_d;
  logic [15:0] perf_illegal_q, perf_illegal_d;
  logic        retire;

  assign retire = (state_q == DONE) && res_ready;

  always_comb begin
    perf_instr_d   = perf_instr_q;
    perf_ovfl_d    = perf_ovfl_q;
    perf_illegal_d = perf_illegal_q;
    if (retire) begin
      perf_instr_d = perf_instr_q + 32'd1;
      if (res_ovfl_q) begin
        perf_ovfl_d = perf_ovfl_q + 16'd1;
      end
      if (res_illegal_q) begin
        perf_illegal_d = perf_illegal_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_q   <= 32'd0;
      perf_ovfl_q    <= 16'd0;
      perf_illegal_q <= 16'd0;
    end else begin
      perf_instr_q   <= perf_instr_d;
      perf_ovfl_q    <= perf_ovfl_d;
      perf_illegal_q <= perf_illegal_d;
    end
  end

  assign perf_instr_cnt   = perf_instr_q;
  assign perf_ovfl_cnt    = perf_ovfl_q;
  assign perf_illegal_cnt = perf_illegal_q;
`endif

endmodule

`default_nettype wire
